// File: rtl/nibble_serial_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_seq_pkg
// Description : Shared constants, state encoding and helpers for the
//               nibble-serial multi-word adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_add_seq_pkg;

  // Width of one slice handled by the ripple adder per cycle
  localparam int NIBBLE_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the nibble index; never narrower than one bit so NIBBLES=1 works
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_adder_4bit_dataflow
// Description : 4-bit ripple-carry adder built from a chain of full-adder
//               equations. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder_4bit_dataflow
  import nibble_serial_add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  // c[i] is the carry into bit i; c[NIBBLE_W] leaves the slice
  logic [NIBBLE_W:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[NIBBLE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_seq
// Description : Accepts two NIBBLES*4-bit operands and a carry-in, adds them
//               one nibble per cycle (LS nibble first) through a single 4-bit
//               ripple adder with a registered carry chain, and returns the
//               full sum and final carry-out over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_seq
  import nibble_serial_add_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b_in,
  input  logic                          cin_in,
  output logic [NIBBLE_W*NIBBLES-1:0]   result,
  output logic                          cout,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic                          busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic                carry_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum_nib;
  logic                carry_nib;

  // Ready is a direct decode of the state flop, so it is high during reset
  assign start_ready = (state == ST_IDLE);

  // Select the operand nibbles addressed by idx
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        a_nib = a_r[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_adder_4bit_dataflow u_slice_adder (
    .a         (a_nib),
    .b         (b_nib),
    .carry_in  (carry_r),
    .sum       (sum_nib),
    .carry_out (carry_nib)
  );

  // Sequencer FSM with operand, carry, index and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      carry_r    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      result     <= '0;
      cout       <= 1'b0;
      done_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_r     <= a_in;
            b_r     <= b_in;
            carry_r <= cin_in;
            result  <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_ADD;
          end
        end

        ST_ADD: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
              result[n*NIBBLE_W +: NIBBLE_W] <= sum_nib;
            end
          end
          carry_r <= carry_nib;
          if (idx == IDX_W'(NIBBLES - 1)) begin
            cout       <= carry_nib;
            idx        <= '0;
            done_valid <= 1'b1;
            state      <= ST_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        ST_DONE: begin
          // Result and cout stay frozen until the consumer takes them
          if (done_ready) begin
            done_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          done_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_seq
// Description : Self-checking bench for nibble_serial_add_seq. A 4-nibble and
//               a 1-nibble instance are driven with directed and random
//               operands; expected sums come from plain wide arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_seq;

  localparam int N4 = 4;
  localparam int N1 = 1;

  logic        clk = 1'b0;
  logic        rst;

  // 4-nibble instance
  logic        sv, sr, ci, co, dv, dr, bsy;
  logic [15:0] a, b, res;

  // 1-nibble instance
  logic        sv1, sr1, ci1, co1, dv1, dr1, bsy1;
  logic [3:0]  a1, b1, res1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  nibble_serial_add_seq #(.NIBBLES(N4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(sv), .start_ready(sr),
    .a_in(a), .b_in(b), .cin_in(ci),
    .result(res), .cout(co),
    .done_valid(dv), .done_ready(dr), .busy(bsy)
  );

  nibble_serial_add_seq #(.NIBBLES(N1)) dut1 (
    .clk(clk), .rst(rst),
    .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .cin_in(ci1),
    .result(res1), .cout(co1),
    .done_valid(dv1), .done_ready(dr1), .busy(bsy1)
  );

  // Cycle counter and record of the cycles on which dut4 accepted a start
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sv === 1'b1 && sr === 1'b1) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on dut4: accept, scramble inputs during ADD, measure
  // latency, hold in DONE for 'hold' cycles, then hand the result off.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic civ, input int hold);
    logic [16:0] exp;
    int          lat;
    exp = {1'b0, av} + {1'b0, bv} + 17'(civ);
    chk("start_ready_idle", sr, 1);
    sv = 1'b1; a = av; b = bv; ci = civ;
    tick();
    sv = 1'b0;
    chk("busy_after_accept", bsy, 1);
    lat = 0;
    while (dv !== 1'b1 && lat < 40) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      tick();
      lat++;
    end
    chk("latency", lat, N4);
    chk("result", res, exp[15:0]);
    chk("cout", co, exp[16]);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_result", res, exp[15:0]);
      chk("hold_valid", dv, 1);
    end
    dr = 1'b1;
    tick();
    dr = 1'b0;
    chk("done_valid_drop", dv, 0);
    chk("start_ready_rise", sr, 1);
  endtask

  // Full transaction on the single-nibble instance
  task automatic run_op1(input logic [3:0] av, input logic [3:0] bv, input logic civ);
    logic [4:0] exp;
    int         lat;
    exp = {1'b0, av} + {1'b0, bv} + 5'(civ);
    chk("n1_start_ready", sr1, 1);
    sv1 = 1'b1; a1 = av; b1 = bv; ci1 = civ;
    tick();
    sv1 = 1'b0;
    lat = 0;
    while (dv1 !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("n1_latency", lat, N1);
    chk("n1_result", res1, exp[3:0]);
    chk("n1_cout", co1, exp[4]);
    dr1 = 1'b1;
    tick();
    dr1 = 1'b0;
    chk("n1_done_valid_drop", dv1, 0);
  endtask

  logic [16:0] e1, e2;
  int          lat;
  int          iv;

  initial begin
    rst = 1'b1;
    sv = 1'b0; a = '0; b = '0; ci = 1'b0; dr = 1'b0;
    sv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; dr1 = 1'b0;
    #1;
    // Reset state
    chk("rst_result", res, 0);
    chk("rst_cout", co, 0);
    chk("rst_done_valid", dv, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_start_ready", sr, 1);
    chk("rst_n1_start_ready", sr1, 1);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Directed arithmetic cases
    run_op(16'h0003, 16'h0006, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

    // Backpressure: a new start is ignored while the result waits in DONE
    e1 = {1'b0, 16'h1357} + {1'b0, 16'hF0F0} + 17'd1;
    sv = 1'b1; a = 16'h1357; b = 16'hF0F0; ci = 1'b1;
    tick();
    sv = 1'b0;
    lat = 0;
    while (dv !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("bp_latency", lat, N4);
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
    e2 = {1'b0, a} + {1'b0, b} + 17'(ci);
    sv = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_result_stable", res, e1[15:0]);
      chk("bp_cout_stable", co, e1[16]);
      chk("bp_valid_stable", dv, 1);
      chk("bp_start_ready_low", sr, 0);
    end
    dr = 1'b1;
    tick();
    dr = 1'b0;
    chk("bp_release_idle", sr, 1);
    chk("bp_release_valid", dv, 0);
    tick();
    sv = 1'b0;
    chk("bp_new_accepted", bsy, 1);
    lat = 0;
    while (dv !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("bp_new_result", res, e2[15:0]);
    chk("bp_new_cout", co, e2[16]);
    dr = 1'b1; tick(); dr = 1'b0;

    // Reset in the middle of an addition
    sv = 1'b1; a = 16'h1234; b = 16'h1111; ci = 1'b0;
    tick();
    sv = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("abort_result", res, 0);
    chk("abort_cout", co, 0);
    chk("abort_done_valid", dv, 0);
    chk("abort_busy", bsy, 0);
    chk("abort_start_ready", sr, 1);
    tick();
    rst = 1'b0;
    tick();
    run_op(16'h1234, 16'h1111, 1'b0, 0);
    chk("rerun_value", res, 16'h2345);

    // Back-to-back with done_ready tied high
    acc_q.delete();
    dr = 1'b1;
    sv = 1'b1; a = 16'h0001; b = 16'h0001; ci = 1'b0;
    lat = 0;
    while (dv !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("b2b_first_result", res, 16'h0002);
    chk("b2b_first_cout", co, 0);
    a = 16'h8000; b = 16'h8000;
    lat = 0;
    while (dv !== 1'b0 && lat < 40) begin tick(); lat++; end
    lat = 0;
    while (dv !== 1'b1 && lat < 40) begin tick(); lat++; end
    chk("b2b_second_result", res, 16'h0000);
    chk("b2b_second_cout", co, 1);
    sv = 1'b0;
    tick();
    dr = 1'b0;
    chk("b2b_accept_count", acc_q.size(), 2);
    iv = (acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : -1;
    chk("b2b_issue_interval", iv, N4 + 2);

    // Random operands against the arithmetic model
    for (int r = 0; r < 16; r++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Single-nibble build
    run_op1(4'hF, 4'h1, 1'b1);
    run_op1(4'hF, 4'hF, 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_op1(4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
